// File: rtl/amm_mem_responder.sv
// Avalon-MM slave over on-chip word memory: WAIT_CYCLES stalls per accept, reads return READ_LATENCY cycles later.
// Reads also stall while MAX_PENDING returns are outstanding; writes never stall on that limit.
module amm_mem_responder #(
  parameter int                      ADDRESSWIDTH = 28,
  parameter int                      DATAWIDTH    = 32,
  parameter int                      MEM_WORDS    = 1024,
  parameter logic [ADDRESSWIDTH-1:0] BASE_ADDR    = 28'h8000000,
  parameter int                      WAIT_CYCLES  = 2,
  parameter int                      READ_LATENCY = 3,
  parameter int                      MAX_PENDING  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDRESSWIDTH-1:0] slave_address,
  input  logic                    slave_read,
  input  logic                    slave_write,
  input  logic [DATAWIDTH-1:0]    slave_writedata,
  output logic                    slave_waitrequest,
  output logic [DATAWIDTH-1:0]    slave_readdata,
  output logic                    slave_readdatavalid,
  output logic [3:0]              pending_count,
  output logic [15:0]             error_count
);

  localparam int WW = $clog2(MEM_WORDS);
  localparam logic [ADDRESSWIDTH:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [ADDRESSWIDTH:0] HI_ADDR = LO_ADDR + (ADDRESSWIDTH+1)'(4 * MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GRANT} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            pending_q, pending_d;
  logic [15:0]           err_q, err_d;
  logic [READ_LATENCY-1:0] vld_q;
  logic [DATAWIDTH-1:0]  dat_q [READ_LATENCY];
  logic [DATAWIDTH-1:0]  mem_q [MEM_WORDS];

  logic                    req, rd_only, full, accept, drop_err;
  logic                    rd_acc, wr_acc, bad_acc, ret;
  logic                    in_range;
  logic [ADDRESSWIDTH-1:0] offs;
  logic [WW-1:0]           word;
  logic [DATAWIDTH-1:0]    rd_data;

  assign req      = slave_read | slave_write;
  assign rd_only  = slave_read & ~slave_write;
  assign full     = rd_only && (pending_q == 4'(MAX_PENDING));
  assign in_range = ({1'b0, slave_address} >= LO_ADDR) && ({1'b0, slave_address} < HI_ADDR);
  assign offs     = slave_address - BASE_ADDR;
  assign word     = WW'(offs >> 2);
  assign rd_data  = in_range ? mem_q[word] : DATAWIDTH'(32'hDEADBEEF);

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    slave_waitrequest = 1'b0;
    accept            = 1'b0;
    drop_err          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            slave_waitrequest = full;
            accept            = ~full;
          end else begin
            slave_waitrequest = 1'b1;
            cnt_d             = 4'd1;
            state_d           = (WAIT_CYCLES >= 2) ? S_WAIT : S_GRANT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d  = S_IDLE;
          cnt_d    = 4'd0;
          drop_err = 1'b1;
        end else begin
          slave_waitrequest = 1'b1;
          if (cnt_q == 4'(WAIT_CYCLES - 1)) state_d = S_GRANT;
          else                              cnt_d   = cnt_q + 4'd1;
        end
      end
      S_GRANT: begin
        if (!req) begin
          state_d  = S_IDLE;
          cnt_d    = 4'd0;
          drop_err = 1'b1;
        end else if (full) begin
          slave_waitrequest = 1'b1;
        end else begin
          accept  = 1'b1;
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Simultaneous read+write is serviced as a write but still logged as bad.
  assign rd_acc    = accept & rd_only;
  assign wr_acc    = accept & slave_write;
  assign bad_acc   = accept & (~in_range | (slave_read & slave_write));
  assign ret       = vld_q[READ_LATENCY-1];
  assign pending_d = pending_q + {3'b000, rd_acc} - {3'b000, ret};
  assign err_d     = ((drop_err | bad_acc) && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      pending_q <= 4'd0;
      err_q     <= 16'd0;
      vld_q     <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      vld_q[0]  <= rd_acc;
      if (rd_acc) dat_q[0] <= rd_data;
      // Each stage only loads on valid, so the last stage holds the previous return.
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && in_range) mem_q[word] <= slave_writedata;
  end

  assign slave_readdatavalid = vld_q[READ_LATENCY-1];
  assign slave_readdata      = dat_q[READ_LATENCY-1];
  assign pending_count       = pending_q;
  assign error_count         = err_q;

endmodule

// File: tb/tb_amm_mem_responder.sv
// Bench for amm_mem_responder: default-parameter instance plus a zero-wait instance with a small pending limit.
module tb_amm_mem_responder;

  localparam logic [27:0] BASE = 28'h8000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_read, a_write, a_waitreq, a_vld;
  logic [27:0] a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic [3:0]  a_pend;
  logic [15:0] a_err;
  logic        f_reset, f_read, f_write, f_waitreq, f_vld;
  logic [27:0] f_addr;
  logic [31:0] f_wdata, f_rdata;
  logic [3:0]  f_pend;
  logic [15:0] f_err;

  amm_mem_responder u_a (
    .clk(clk), .reset(a_reset), .slave_address(a_addr), .slave_read(a_read),
    .slave_write(a_write), .slave_writedata(a_wdata), .slave_waitrequest(a_waitreq),
    .slave_readdata(a_rdata), .slave_readdatavalid(a_vld), .pending_count(a_pend),
    .error_count(a_err)
  );

  amm_mem_responder #(.WAIT_CYCLES(0), .READ_LATENCY(3), .MAX_PENDING(2)) u_f (
    .clk(clk), .reset(f_reset), .slave_address(f_addr), .slave_read(f_read),
    .slave_write(f_write), .slave_writedata(f_wdata), .slave_waitrequest(f_waitreq),
    .slave_readdata(f_rdata), .slave_readdatavalid(f_vld), .pending_count(f_pend),
    .error_count(f_err)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] a_mem [1024];
  logic [31:0] f_mem [1024];
  logic [31:0] a_q [$];
  logic [31:0] f_q [$];
  logic        a_ws, a_vs, f_ws, f_vs;
  int          f_exp_pend = 0;
  int          f_ret_cnt = 0;
  bit          f_full_seen = 1'b0;
  bit          f_chk_en = 1'b0;

  function automatic bit in_rng(input logic [27:0] ad);
    return (ad >= BASE) && ({1'b0, ad} < ({1'b0, BASE} + 29'd4096));
  endfunction

  function automatic logic [9:0] word_of(input logic [27:0] ad);
    logic [27:0] o;
    o = ad - BASE;
    return o[11:2];
  endfunction

  // Advance one cycle: sample at negedge, run both scoreboards, return at posedge+1.
  task automatic cycle();
    logic [31:0] e;
    @(negedge clk);
    a_ws = a_waitreq; a_vs = a_vld; f_ws = f_waitreq; f_vs = f_vld;
    if (a_vld) begin
      checks++;
      if (a_q.size() == 0) begin
        errors++; $display("FAIL a_unexpected_return: got readdatavalid=1 data %h, expected none", a_rdata);
      end else begin
        e = a_q.pop_front();
        if (a_rdata !== e) begin errors++; $display("FAIL a_read_data: got %h expected %h", a_rdata, e); end
      end
    end
    if (a_reset) a_q.delete();
    else if ((a_read || a_write) && !a_waitreq) begin
      if (a_write) begin if (in_rng(a_addr)) a_mem[word_of(a_addr)] = a_wdata; end
      else a_q.push_back(in_rng(a_addr) ? a_mem[word_of(a_addr)] : 32'hDEADBEEF);
    end
    if (f_vld) begin
      checks++; f_ret_cnt++;
      if (f_q.size() == 0) begin
        errors++; $display("FAIL f_unexpected_return: got readdatavalid=1 data %h, expected none", f_rdata);
      end else begin
        e = f_q.pop_front();
        if (f_rdata !== e) begin errors++; $display("FAIL f_read_data: got %h expected %h", f_rdata, e); end
      end
    end
    if (f_chk_en) begin
      checks++;
      if (f_pend !== 4'(f_exp_pend)) begin
        errors++; $display("FAIL f_pending: got %0d expected %0d", f_pend, f_exp_pend);
      end
      if (f_read && !f_write && f_exp_pend == 2) begin
        checks++; f_full_seen = 1'b1;
        if (f_waitreq !== 1'b1) begin errors++; $display("FAIL f_full_stall: got waitrequest %b expected 1", f_waitreq); end
      end
    end
    f_exp_pend = f_reset ? 0 : f_exp_pend + ((f_read && !f_write && !f_waitreq) ? 1 : 0) - (f_vld ? 1 : 0);
    if (f_reset) f_q.delete();
    else if ((f_read || f_write) && !f_waitreq) begin
      if (f_write) begin if (in_rng(f_addr)) f_mem[word_of(f_addr)] = f_wdata; end
      else f_q.push_back(in_rng(f_addr) ? f_mem[word_of(f_addr)] : 32'hDEADBEEF);
    end
    @(posedge clk); #1;
  endtask

  task automatic a_access(input logic rd, input logic wr, input logic [27:0] ad, input logic [31:0] wd, output int waits);
    bit acc;
    acc = 1'b0; waits = 0;
    a_read = rd; a_write = wr; a_addr = ad; a_wdata = wd;
    for (int n = 0; n < 40; n++) begin
      cycle();
      if (!a_ws) begin acc = 1'b1; break; end
      waits++;
    end
    a_read = 1'b0; a_write = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL a_access_timeout: got no accept expected accept for addr %h", ad); end
  endtask

  task automatic f_access(input logic rd, input logic wr, input logic [27:0] ad, input logic [31:0] wd);
    bit acc;
    acc = 1'b0;
    f_read = rd; f_write = wr; f_addr = ad; f_wdata = wd;
    for (int n = 0; n < 40; n++) begin
      cycle();
      if (!f_ws) begin acc = 1'b1; break; end
    end
    f_read = 1'b0; f_write = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL f_access_timeout: got no accept expected accept for addr %h", ad); end
  endtask

  task automatic drain();
    for (int n = 0; n < 30; n++) begin
      if (a_q.size() == 0 && f_q.size() == 0) break;
      cycle();
    end
    checks++;
    if (a_q.size() != 0 || f_q.size() != 0) begin
      errors++; $display("FAIL drain: got %0d/%0d outstanding expected 0/0", a_q.size(), f_q.size());
    end
  endtask

  task automatic test_reset();
    a_reset = 1'b1; f_reset = 1'b1;
    a_read = 0; a_write = 0; a_addr = BASE; a_wdata = 0;
    f_read = 0; f_write = 0; f_addr = BASE; f_wdata = 0;
    repeat (3) cycle();
    a_reset = 1'b0; f_reset = 1'b0; f_chk_en = 1'b1;
    checks += 9;
    if (a_vld !== 1'b0)    begin errors++; $display("FAIL reset_a_vld: got %b expected 0", a_vld); end
    if (a_rdata !== 32'd0) begin errors++; $display("FAIL reset_a_rdata: got %h expected 0", a_rdata); end
    if (a_pend !== 4'd0)   begin errors++; $display("FAIL reset_a_pend: got %0d expected 0", a_pend); end
    if (a_err !== 16'd0)   begin errors++; $display("FAIL reset_a_err: got %0d expected 0", a_err); end
    if (a_waitreq !== 1'b0) begin errors++; $display("FAIL reset_a_wait: got %b expected 0", a_waitreq); end
    if (f_vld !== 1'b0)    begin errors++; $display("FAIL reset_f_vld: got %b expected 0", f_vld); end
    if (f_rdata !== 32'd0) begin errors++; $display("FAIL reset_f_rdata: got %h expected 0", f_rdata); end
    if (f_pend !== 4'd0)   begin errors++; $display("FAIL reset_f_pend: got %0d expected 0", f_pend); end
    if (f_err !== 16'd0)   begin errors++; $display("FAIL reset_f_err: got %0d expected 0", f_err); end
  endtask

  task automatic test_write_read();
    int w, lat;
    a_access(1'b0, 1'b1, 28'h8000010, 32'hA5A50001, w);
    checks++;
    if (w !== 2) begin errors++; $display("FAIL wr_wait_cycles: got %0d expected 2", w); end
    a_access(1'b1, 1'b0, 28'h8000010, 32'd0, w);
    checks += 2;
    if (w !== 2) begin errors++; $display("FAIL rd_wait_cycles: got %0d expected 2", w); end
    if (a_pend !== 4'd1) begin errors++; $display("FAIL rd_pending_one: got %0d expected 1", a_pend); end
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      cycle();
      if (a_vs) begin lat = n; break; end
    end
    checks += 3;
    if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    if (a_pend !== 4'd0) begin errors++; $display("FAIL rd_pending_zero: got %0d expected 0", a_pend); end
    if (a_rdata !== 32'hA5A50001) begin errors++; $display("FAIL rd_data_hold: got %h expected a5a50001", a_rdata); end
  endtask

  task automatic test_out_of_range();
    int w;
    a_access(1'b0, 1'b1, 28'h8000000, 32'hCAFE0000, w);
    a_access(1'b0, 1'b1, 28'h8000FFC, 32'h0000FFFC, w);
    a_access(1'b1, 1'b0, 28'h8001000, 32'd0, w);
    drain();
    checks += 2;
    if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL oor_rd_data: got %h expected deadbeef", a_rdata); end
    if (a_err !== 16'd1) begin errors++; $display("FAIL oor_rd_err: got %0d expected 1", a_err); end
    a_access(1'b0, 1'b1, 28'h8001000, 32'h11111111, w);
    checks++;
    if (a_err !== 16'd2) begin errors++; $display("FAIL oor_wr_err: got %0d expected 2", a_err); end
    a_access(1'b1, 1'b0, 28'h7FFFFFC, 32'd0, w);
    drain();
    checks++;
    if (a_err !== 16'd3) begin errors++; $display("FAIL below_base_err: got %0d expected 3", a_err); end
    a_access(1'b1, 1'b0, 28'h8000000, 32'd0, w);
    a_access(1'b1, 1'b0, 28'h8000FFC, 32'd0, w);
    drain();
    checks += 2;
    if (a_rdata !== 32'h0000FFFC) begin errors++; $display("FAIL last_word: got %h expected 0000fffc", a_rdata); end
    if (a_err !== 16'd3) begin errors++; $display("FAIL in_range_no_err: got %0d expected 3", a_err); end
  endtask

  task automatic test_rw_both();
    int w, nv;
    a_access(1'b1, 1'b1, 28'h800001C, 32'h12345678, w);
    nv = 0;
    repeat (6) begin cycle(); if (a_vs) nv++; end
    checks += 3;
    if (nv !== 0) begin errors++; $display("FAIL rw_no_return: got %0d returns expected 0", nv); end
    if (a_pend !== 4'd0) begin errors++; $display("FAIL rw_pending: got %0d expected 0", a_pend); end
    if (a_err !== 16'd4) begin errors++; $display("FAIL rw_err: got %0d expected 4", a_err); end
    a_access(1'b1, 1'b0, 28'h800001C, 32'd0, w);
    drain();
    checks++;
    if (a_rdata !== 32'h12345678) begin errors++; $display("FAIL rw_mem7: got %h expected 12345678", a_rdata); end
  endtask

  task automatic test_drop();
    int w;
    a_read = 1'b1; a_addr = 28'h8000010;
    cycle();
    checks++;
    if (a_ws !== 1'b1) begin errors++; $display("FAIL drop_wait_first: got %b expected 1", a_ws); end
    a_read = 1'b0;
    cycle();
    checks += 2;
    if (a_ws !== 1'b0) begin errors++; $display("FAIL drop_wait_noreq: got %b expected 0", a_ws); end
    if (a_err !== 16'd5) begin errors++; $display("FAIL drop_err: got %0d expected 5", a_err); end
    a_access(1'b1, 1'b0, 28'h8000010, 32'd0, w);
    checks++;
    if (w !== 2) begin errors++; $display("FAIL drop_next_wait: got %0d expected 2", w); end
    drain();
  endtask

  task automatic test_back_to_back();
    int acc, cyc;
    for (int i = 0; i < 6; i++) begin
      f_write = 1'b1; f_addr = BASE + 28'(4 * i); f_wdata = 32'(i);
      cycle();
      checks++;
      if (f_ws !== 1'b0) begin errors++; $display("FAIL b2b_preload_wait: got %b expected 0", f_ws); end
    end
    f_write = 1'b0;
    f_ret_cnt = 0; f_full_seen = 1'b0;
    acc = 0; cyc = 0;
    f_read = 1'b1; f_addr = BASE;
    for (int n = 0; n < 60 && acc < 6; n++) begin
      cycle(); cyc++;
      if (!f_ws) begin acc++; f_addr = BASE + 28'(4 * acc); end
    end
    f_read = 1'b0;
    drain();
    checks += 4;
    if (acc !== 6) begin errors++; $display("FAIL b2b_accepts: got %0d expected 6", acc); end
    if (cyc !== 10) begin errors++; $display("FAIL b2b_cycles: got %0d expected 10", cyc); end
    if (f_ret_cnt !== 6) begin errors++; $display("FAIL b2b_returns: got %0d expected 6", f_ret_cnt); end
    if (f_full_seen !== 1'b1) begin errors++; $display("FAIL b2b_full_seen: got %b expected 1", f_full_seen); end
  endtask

  task automatic test_reset_inflight();
    int nv;
    f_access(1'b0, 1'b1, BASE + 28'd36, 32'h0BADF00D);
    f_access(1'b1, 1'b0, 28'h8001000, 32'd0);
    drain();
    checks++;
    if (f_err !== 16'd1) begin errors++; $display("FAIL rst_pre_err: got %0d expected 1", f_err); end
    f_read = 1'b1; f_addr = BASE + 28'd36;
    repeat (2) begin
      cycle();
      checks++;
      if (f_ws !== 1'b0) begin errors++; $display("FAIL rst_inflight_accept: got %b expected 0", f_ws); end
    end
    f_read = 1'b0; f_reset = 1'b1;
    cycle();
    f_reset = 1'b0;
    nv = 0;
    repeat (8) begin cycle(); if (f_vs) nv++; end
    checks += 4;
    if (nv !== 0) begin errors++; $display("FAIL rst_no_return: got %0d returns expected 0", nv); end
    if (f_pend !== 4'd0) begin errors++; $display("FAIL rst_pending: got %0d expected 0", f_pend); end
    if (f_err !== 16'd0) begin errors++; $display("FAIL rst_err: got %0d expected 0", f_err); end
    if (f_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", f_rdata); end
    f_access(1'b1, 1'b0, BASE + 28'd36, 32'd0);
    drain();
    checks++;
    if (f_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL rst_mem_kept: got %h expected 0badf00d", f_rdata); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_rw_both();
    test_drop();
    test_back_to_back();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
